// File: rtl/udp_parser.sv
// udp_parser: strips the 8-byte UDP header from the IP payload stream and forwards the payload.
// Define UDP_PORT_FILTER_EN to drop frames whose destination port differs from UDP_PORT.
module udp_parser #(
  parameter logic [15:0] UDP_PORT = 16'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ip_data_in,
  input  logic        ip_byte_valid,
  input  logic        ip_eof,
  input  logic        ip_err,
  output logic [7:0]  udp_data_out,
  output logic        udp_byte_valid,
  output logic        udp_eof,
  output logic        udp_err,
  output logic [15:0] udp_src_port,
  output logic [15:0] udp_len
);

  typedef enum logic [1:0] {StHeader, StPayload, StDrop} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] hdr_src_q, hdr_src_d;
  logic [15:0] hdr_len_q, hdr_len_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] len_q, len_d;
  logic        port_ok;

`ifdef UDP_PORT_FILTER_EN
  logic [15:0] hdr_dst_q, hdr_dst_d;
  assign port_ok = (hdr_dst_q == UDP_PORT);
`else
  assign port_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    hdr_src_d  = hdr_src_q;
    hdr_len_d  = hdr_len_q;
`ifdef UDP_PORT_FILTER_EN
    hdr_dst_d  = hdr_dst_q;
`endif
    data_d     = data_q;
    valid_d    = 1'b0;
    eof_d      = 1'b0;
    err_d      = 1'b0;
    src_port_d = src_port_q;
    len_d      = len_q;

    if (ip_byte_valid) begin
      cnt_d = cnt_q + 16'd1;
      case (state_q)
        StHeader: begin
          case (cnt_q)
            16'd0: hdr_src_d[15:8] = ip_data_in;
            16'd1: hdr_src_d[7:0]  = ip_data_in;
`ifdef UDP_PORT_FILTER_EN
            16'd2: hdr_dst_d[15:8] = ip_data_in;
            16'd3: hdr_dst_d[7:0]  = ip_data_in;
`endif
            16'd4: hdr_len_d[15:8] = ip_data_in;
            16'd5: hdr_len_d[7:0]  = ip_data_in;
            16'd7: begin
              // Checksum bytes 6-7 are ignored; all other fields are complete here.
              src_port_d = hdr_src_q;
              len_d      = hdr_len_q;
              if (hdr_len_q < 16'd8 || !port_ok) begin
                state_d = StDrop;
              end else begin
                state_d = StPayload;
                rem_d   = hdr_len_q - 16'd8;
              end
            end
            default: ;
          endcase
        end
        StPayload: begin
          // Bytes beyond the UDP length are link padding and vanish silently.
          if (rem_q != 16'd0) begin
            data_d  = ip_data_in;
            valid_d = 1'b1;
            rem_d   = rem_q - 16'd1;
          end
        end
        default: ;
      endcase
    end

    // Termination sees the state after this cycle's byte has been consumed.
    if (ip_eof || ip_err) begin
      eof_d   = 1'b1;
      err_d   = ip_err || (state_d == StHeader) || (state_d == StDrop) ||
                ((state_d == StPayload) && (rem_d != 16'd0));
      state_d = StHeader;
      cnt_d   = 16'd0;
      rem_d   = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHeader;
      cnt_q      <= 16'd0;
      rem_q      <= 16'd0;
      hdr_src_q  <= 16'd0;
      hdr_len_q  <= 16'd0;
`ifdef UDP_PORT_FILTER_EN
      hdr_dst_q  <= 16'd0;
`endif
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      eof_q      <= 1'b0;
      err_q      <= 1'b0;
      src_port_q <= 16'd0;
      len_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      hdr_src_q  <= hdr_src_d;
      hdr_len_q  <= hdr_len_d;
`ifdef UDP_PORT_FILTER_EN
      hdr_dst_q  <= hdr_dst_d;
`endif
      data_q     <= data_d;
      valid_q    <= valid_d;
      eof_q      <= eof_d;
      err_q      <= err_d;
      src_port_q <= src_port_d;
      len_q      <= len_d;
    end
  end

  assign udp_data_out   = data_q;
  assign udp_byte_valid = valid_q;
  assign udp_eof        = eof_q;
  assign udp_err        = err_q;
  assign udp_src_port   = src_port_q;
  assign udp_len        = len_q;

endmodule
